// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode-class decode
// helpers for the ALU op sequencer (also usable by the ALU and decode stages).
package alu_op_sequencer_pkg;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_WB_LO   = 3'd3,
    ST_WB_HI   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Unary ops only read operand B; operand A fetch is skipped.
  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Long ops produce a full 64-bit result and need extra ALU settle cycles.
  function automatic logic is_long(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for one register-to-register ALU op over the shared bus.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | waiting for start; fields captured on accept
//  FETCH_A  | ra drives bus, Y loads (skipped for unary ops)
//  FETCH_B  | rb drives bus; long ops hold here until the wait count is 0
//  WB_LO    | Z[31:0] drives bus into rc (short) or LO (long)
//  WB_HI    | Z[63:32] drives bus into HI (long ops only)
//  DONE     | one-cycle done pulse, err_illegal for unknown opcodes
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int REG_SEL_W     = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [4:0]           opcode_in,
  input  logic [REG_SEL_W-1:0] ra,
  input  logic [REG_SEL_W-1:0] rb,
  input  logic [REG_SEL_W-1:0] rc,
  output logic                 busy,
  output logic                 done,
  output logic                 err_illegal,
  output logic [REG_SEL_W-1:0] reg_sel,
  output logic                 reg_out_en,
  output logic                 reg_in_en,
  output logic                 y_in,
  output logic                 z_in,
  output logic                 zlo_out,
  output logic                 zhi_out,
  output logic                 lo_in,
  output logic                 hi_in,
  output logic [4:0]           alu_opcode
);

  localparam int              CNT_W    = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [4:0]             op_q, op_d;
  logic [REG_SEL_W-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   long_op;
  logic                   wait_over;

  assign long_op   = is_long(op_q);
  // Short ops latch Z on the first FETCH_B cycle; long ops once the count hits 0.
  assign wait_over = !long_op || (cnt_q == '0);

  // State, captured op fields and wait counter registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, field capture and wait-count update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = opcode_in;
          ra_d  = ra;
          rb_d  = rb;
          rc_d  = rc;
          cnt_d = CNT_LOAD;
          if (!is_legal(opcode_in))     state_d = ST_DONE;
          else if (is_unary(opcode_in)) state_d = ST_FETCH_B;
          else                          state_d = ST_FETCH_A;
        end
      end
      ST_FETCH_A: state_d = ST_FETCH_B;
      ST_FETCH_B: begin
        if (wait_over) state_d = ST_WB_LO;
        else           cnt_d   = cnt_q - 1'b1;
      end
      ST_WB_LO:   state_d = long_op ? ST_WB_HI : ST_DONE;
      ST_WB_HI:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from the registered state and captured fields.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err_illegal = 1'b0;
    reg_sel     = '0;
    reg_out_en  = 1'b0;
    reg_in_en   = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    zlo_out     = 1'b0;
    zhi_out     = 1'b0;
    lo_in       = 1'b0;
    hi_in       = 1'b0;
    alu_opcode  = '0;
    if (state_q != ST_IDLE) begin
      busy       = 1'b1;
      alu_opcode = op_q;
    end
    case (state_q)
      ST_FETCH_A: begin
        reg_sel    = ra_q;
        reg_out_en = 1'b1;
        y_in       = 1'b1;
      end
      ST_FETCH_B: begin
        reg_sel    = rb_q;
        reg_out_en = 1'b1;
        z_in       = wait_over;
      end
      ST_WB_LO: begin
        zlo_out = 1'b1;
        if (long_op) begin
          lo_in = 1'b1;
        end else begin
          reg_sel   = rc_q;
          reg_in_en = 1'b1;
        end
      end
      ST_WB_HI: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      ST_DONE: begin
        done        = 1'b1;
        err_illegal = !is_legal(op_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench: per-op expected output traces built from the
// op-sequencing rules and compared cycle by cycle against the sequencer.
module tb_alu_op_sequencer;

  localparam int M = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [4:0] opcode_in;
  logic [3:0] ra, rb, rc;
  logic       busy, done, err_illegal;
  logic [3:0] reg_sel;
  logic       reg_out_en, reg_in_en, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
  logic [4:0] alu_opcode;

  int errors = 0;
  int checks = 0;

  logic [20:0] exp_q[$];
  logic [4:0]  legal_ops[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  alu_op_sequencer #(.MULDIV_CYCLES(M), .REG_SEL_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode_in(opcode_in),
    .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .err_illegal(err_illegal), .reg_sel(reg_sel),
    .reg_out_en(reg_out_en), .reg_in_en(reg_in_en), .y_in(y_in), .z_in(z_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
    .alu_opcode(alu_opcode)
  );

  always #5 clk = ~clk;

  // {busy,done,err,sel[4],out_en,in_en,y,z,zlo,zhi,lo,hi,opcode[5]}
  logic [20:0] obs;
  assign obs = {busy, done, err_illegal, reg_sel, reg_out_en, reg_in_en, y_in, z_in,
                zlo_out, zhi_out, lo_in, hi_in, alu_opcode};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic void push(input bit oe, input bit ie, input bit y, input bit z,
                               input bit zlo, input bit zhi, input bit lo, input bit hi,
                               input bit dn, input bit er, input logic [3:0] sel,
                               input logic [4:0] opc);
    exp_q.push_back({1'b1, dn, er, sel, oe, ie, y, z, zlo, zhi, lo, hi, opc});
  endfunction

  // Expected busy-period trace, one entry per cycle after the accept edge.
  function automatic void build(input logic [4:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] c);
    bit legal = 0;
    bit lng   = (op == 5'd15) || (op == 5'd16);
    bit un    = (op == 5'd17) || (op == 5'd18);
    int nb;
    exp_q.delete();
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1;
    if (!legal) begin
      push(0,0,0,0,0,0,0,0, 1,1, 4'd0, op);
      return;
    end
    if (!un) push(1,0,1,0,0,0,0,0, 0,0, a, op);
    nb = lng ? M : 1;
    for (int i = 0; i < nb; i++) push(1,0,0,(i == nb-1),0,0,0,0, 0,0, b, op);
    if (lng) begin
      push(0,0,0,0,1,0,1,0, 0,0, 4'd0, op);
      push(0,0,0,0,0,1,0,1, 0,0, 4'd0, op);
    end else begin
      push(0,1,0,0,1,0,0,0, 0,0, c, op);
    end
    push(0,0,0,0,0,0,0,0, 1,0, 4'd0, op);
  endfunction

  // Accept one op from IDLE and check every cycle up to and including DONE,
  // scrambling start and the fields while busy (they must be ignored).
  task automatic run_op(input string name, input logic [4:0] op,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    check_val($sformatf("%s:idle", name), 32'(obs), 32'd0);
    start = 1'b1; opcode_in = op; ra = a; rb = b; rc = c;
    build(op, a, b, c);
    foreach (exp_q[k]) begin
      @(negedge clk);
      check_val($sformatf("%s:op%0d:c%0d", name, op, k+1), 32'(obs), 32'(exp_q[k]));
      start     = 1'($urandom_range(0, 1));
      opcode_in = 5'($urandom);
      ra        = 4'($urandom);
      rb        = 4'($urandom);
      rc        = 4'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    clr = 1'b0; start = 1'b0; opcode_in = '0; ra = '0; rb = '0; rc = '0;
    #12;
    check_val("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk); clr = 1'b1;

    run_op("add", 5'd3, 4'd1, 4'd2, 4'd3);
    run_op("not", 5'd18, 4'd9, 4'd5, 4'd6);
    run_op("mul", 5'd15, 4'd7, 4'd8, 4'd9);
    run_op("illegal", 5'd31, 4'd1, 4'd1, 4'd1);
    run_op("div_alias", 5'd16, 4'd4, 4'd4, 4'd4);

    // Reset in the middle of a MUL operand-B hold: everything drops, no write-back.
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode_in = 5'd15; ra = 4'd2; rb = 4'd3; rc = 4'd4;
    @(negedge clk); start = 1'b0;
    check_val("rst_mid:fetch_a", 32'(obs), 32'({1'b1, 2'b00, 4'd2, 8'b1010_0000, 5'd15}));
    @(negedge clk);
    #1 clr = 1'b0;
    #1 check_val("rst_mid:async", 32'(obs), 32'd0);
    @(negedge clk);
    check_val("rst_mid:held", 32'(obs), 32'd0);
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("rst_mid:after%0d", i), 32'(obs), 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else                           op = legal_ops[$urandom_range(0, 12)];
      run_op($sformatf("rnd%0d", n), op, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    start = 1'b0;
    @(negedge clk);
    check_val("final_idle", 32'(obs), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
